// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS datapath: default widths,
// ALUOp encodings and the hard-wired zero register specifier.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int PC_W   = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_load_use.sv
// Load-use comparator: flags a load in EX whose destination is read by the
// instruction currently in ID. Purely combinational.
module hazard_load_use
  import mips_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic         ex_valid,
  input  logic         ex_mem_read,
  input  logic [W-1:0] ex_rt,
  input  logic         id_valid,
  input  logic [W-1:0] id_rs,
  input  logic [W-1:0] id_rt,
  output logic         load_use_stall
);

  localparam logic [W-1:0] ZERO_REG = W'(REG_ZERO);

  logic ex_is_load;
  logic rs_match;
  logic rt_match;

  // $zero is never a real dependency, even when a load targets it
  assign ex_is_load = ex_valid & ex_mem_read & (ex_rt != ZERO_REG);
  assign rs_match   = (ex_rt == id_rs);
  assign rt_match   = (ex_rt == id_rt);

  assign load_use_stall = ex_is_load & id_valid & (rs_match | rt_match);

endmodule

// File: rtl/pipe_reg_id_ex.sv
// ID/EX pipeline register with stall hold, flush/load-use bubble insertion,
// per-entry valid bit and a saturating bubble counter.
module pipe_reg_id_ex
  import mips_pkg::*;
#(
  parameter int B    = DATA_W,
  parameter int W    = REG_W,
  parameter int PCW  = PC_W,
  parameter int AOPW = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            valid_in,
  input  logic [PCW-1:0]  pc_next_in,
  input  logic [B-1:0]    r_data1_in,
  input  logic [B-1:0]    r_data2_in,
  input  logic [B-1:0]    sign_ext_in,
  input  logic [W-1:0]    rs_in,
  input  logic [W-1:0]    rt_in,
  input  logic [W-1:0]    rd_in,
  input  logic            wb_RegWrite_in,
  input  logic            wb_MemtoReg_in,
  input  logic            m_Branch_in,
  input  logic            m_MemRead_in,
  input  logic            m_MemWrite_in,
  input  logic            ex_RegDst_in,
  input  logic            ex_ALUSrc_in,
  input  logic [AOPW-1:0] ex_ALUOp_in,
  output logic [PCW-1:0]  pc_next_out,
  output logic [B-1:0]    r_data1_out,
  output logic [B-1:0]    r_data2_out,
  output logic [B-1:0]    sign_ext_out,
  output logic [W-1:0]    rs_out,
  output logic [W-1:0]    rt_out,
  output logic [W-1:0]    rd_out,
  output logic            wb_RegWrite_out,
  output logic            wb_MemtoReg_out,
  output logic            m_Branch_out,
  output logic            m_MemRead_out,
  output logic            m_MemWrite_out,
  output logic            ex_RegDst_out,
  output logic            ex_ALUSrc_out,
  output logic [AOPW-1:0] ex_ALUOp_out,
  output logic            valid_out,
  output logic            load_use_stall,
  output logic [CNTW-1:0] bubble_count
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic insert_bubble;
  logic do_load;

  hazard_load_use #(.W(W)) u_hazard (
    .ex_valid       (valid_out),
    .ex_mem_read    (m_MemRead_out),
    .ex_rt          (rt_out),
    .id_valid       (valid_in),
    .id_rs          (rs_in),
    .id_rt          (rt_in),
    .load_use_stall (load_use_stall)
  );

  // stall masks a load-use bubble, but a flush always wins
  assign insert_bubble = flush_in | (~stall_in & load_use_stall);
  assign do_load       = ~stall_in & ~load_use_stall & ~flush_in;

  // Data and specifiers only move on a real load; bubbles leave them parked
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_next_out  <= '0;
      r_data1_out  <= '0;
      r_data2_out  <= '0;
      sign_ext_out <= '0;
      rs_out       <= '0;
      rt_out       <= '0;
      rd_out       <= '0;
    end else if (do_load) begin
      pc_next_out  <= pc_next_in;
      r_data1_out  <= r_data1_in;
      r_data2_out  <= r_data2_in;
      sign_ext_out <= sign_ext_in;
      rs_out       <= rs_in;
      rt_out       <= rt_in;
      rd_out       <= rd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || insert_bubble) begin
      wb_RegWrite_out <= 1'b0;
      wb_MemtoReg_out <= 1'b0;
      m_Branch_out    <= 1'b0;
      m_MemRead_out   <= 1'b0;
      m_MemWrite_out  <= 1'b0;
      ex_RegDst_out   <= 1'b0;
      ex_ALUSrc_out   <= 1'b0;
      ex_ALUOp_out    <= '0;
      valid_out       <= 1'b0;
    end else if (do_load) begin
      wb_RegWrite_out <= wb_RegWrite_in;
      wb_MemtoReg_out <= wb_MemtoReg_in;
      m_Branch_out    <= m_Branch_in;
      m_MemRead_out   <= m_MemRead_in;
      m_MemWrite_out  <= m_MemWrite_in;
      ex_RegDst_out   <= ex_RegDst_in;
      ex_ALUSrc_out   <= ex_ALUSrc_in;
      ex_ALUOp_out    <= ex_ALUOp_in;
      valid_out       <= valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (insert_bubble && (bubble_count != CNT_MAX)) begin
      bubble_count <= bubble_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_reg_id_ex.sv
// Bench for pipe_reg_id_ex: directed plan steps followed by random traffic,
// all checked against an abstract model of the ID/EX entry.
module tb_pipe_reg_id_ex;

  localparam int B    = 32;
  localparam int W    = 5;
  localparam int PCW  = 32;
  localparam int AOPW = 2;
  localparam int CNTW = 3;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, stall_in, flush_in, valid_in;
  logic [PCW-1:0]  pc_i;
  logic [B-1:0]    d1_i, d2_i, se_i;
  logic [W-1:0]    rs_i, rt_i, rd_i;
  // {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc, ALUOp[1:0]}
  logic [8:0]      ctl_i;

  logic [PCW-1:0]  pc_o;
  logic [B-1:0]    d1_o, d2_o, se_o;
  logic [W-1:0]    rs_o, rt_o, rd_o;
  logic            rw_o, m2r_o, br_o, mr_o, mw_o, rdst_o, asrc_o;
  logic [AOPW-1:0] aop_o;
  logic            valid_o, lus_o;
  logic [CNTW-1:0] cnt_o;
  logic [8:0]      ctl_o;
  assign ctl_o = {rw_o, m2r_o, br_o, mr_o, mw_o, rdst_o, asrc_o, aop_o};

  pipe_reg_id_ex #(.B(B), .W(W), .PCW(PCW), .AOPW(AOPW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .pc_next_in(pc_i), .r_data1_in(d1_i), .r_data2_in(d2_i),
    .sign_ext_in(se_i), .rs_in(rs_i), .rt_in(rt_i), .rd_in(rd_i),
    .wb_RegWrite_in(ctl_i[8]), .wb_MemtoReg_in(ctl_i[7]), .m_Branch_in(ctl_i[6]),
    .m_MemRead_in(ctl_i[5]), .m_MemWrite_in(ctl_i[4]), .ex_RegDst_in(ctl_i[3]),
    .ex_ALUSrc_in(ctl_i[2]), .ex_ALUOp_in(ctl_i[1:0]),
    .pc_next_out(pc_o), .r_data1_out(d1_o), .r_data2_out(d2_o), .sign_ext_out(se_o),
    .rs_out(rs_o), .rt_out(rt_o), .rd_out(rd_o),
    .wb_RegWrite_out(rw_o), .wb_MemtoReg_out(m2r_o), .m_Branch_out(br_o),
    .m_MemRead_out(mr_o), .m_MemWrite_out(mw_o), .ex_RegDst_out(rdst_o),
    .ex_ALUSrc_out(asrc_o), .ex_ALUOp_out(aop_o),
    .valid_out(valid_o), .load_use_stall(lus_o), .bubble_count(cnt_o)
  );

  // Reference model of the EX-side entry
  logic [PCW-1:0] e_pc;
  logic [B-1:0]   e_d1, e_d2, e_se;
  logic [W-1:0]   e_rs, e_rt, e_rd;
  logic [8:0]     e_ctl;
  logic           e_valid;
  int             e_cnt;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hazard();
    // a valid load in EX whose nonzero target is a source of the ID instruction
    return e_valid && e_ctl[5] && valid_in && (e_rt != 0) && (e_rt == rs_i || e_rt == rt_i);
  endfunction

  task automatic model_edge();
    logic hz;
    hz = model_hazard();
    if (reset) begin
      e_pc = '0; e_d1 = '0; e_d2 = '0; e_se = '0;
      e_rs = '0; e_rt = '0; e_rd = '0; e_ctl = '0; e_valid = 1'b0; e_cnt = 0;
    end else if (flush_in || (!stall_in && hz)) begin
      e_ctl = '0; e_valid = 1'b0;
      if (e_cnt < CMAX) e_cnt++;
    end else if (!stall_in) begin
      e_pc = pc_i; e_d1 = d1_i; e_d2 = d2_i; e_se = se_i;
      e_rs = rs_i; e_rt = rt_i; e_rd = rd_i; e_ctl = ctl_i; e_valid = valid_in;
    end
  endtask

  task automatic check_all();
    check("pc_next", 64'(pc_o), 64'(e_pc));
    check("r_data1", 64'(d1_o), 64'(e_d1));
    check("r_data2", 64'(d2_o), 64'(e_d2));
    check("sign_ext", 64'(se_o), 64'(e_se));
    check("specifiers", 64'({rs_o, rt_o, rd_o}), 64'({e_rs, e_rt, e_rd}));
    check("controls", 64'(ctl_o), 64'(e_ctl));
    check("valid_out", 64'(valid_o), 64'(e_valid));
    check("bubble_count", 64'(cnt_o), 64'(e_cnt));
  endtask

  // Inputs are set by the caller right after an edge; step checks the
  // hazard output, takes the edge and compares the new register state.
  task automatic step();
    #1;
    check("load_use_stall", 64'(lus_o), 64'(model_hazard()));
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    reset = 0; stall_in = 0; flush_in = 0; valid_in = 0;
    pc_i = '0; d1_i = '0; d2_i = '0; se_i = '0;
    rs_i = '0; rt_i = '0; rd_i = '0; ctl_i = '0;
  endtask

  initial begin
    idle_inputs();
    e_pc = '0; e_d1 = '0; e_d2 = '0; e_se = '0;
    e_rs = '0; e_rt = '0; e_rd = '0; e_ctl = '0; e_valid = 1'b0; e_cnt = 0;
    @(posedge clk); #1;

    // reset for two cycles with junk on the inputs
    reset = 1; valid_in = 1; d1_i = 32'h5555_AAAA; ctl_i = '1; flush_in = 1;
    step(); step();
    check("reset_valid", 64'(valid_o), 64'(0));
    check("reset_count", 64'(cnt_o), 64'(0));

    // first load
    idle_inputs();
    d1_i = 32'hDEADBEEF; rt_i = 5; valid_in = 1; ctl_i[8] = 1;
    step();
    check("load_r_data1", 64'(d1_o), 64'h0000_0000_DEAD_BEEF);
    check("load_rt", 64'(rt_o), 64'(5));
    check("load_valid", 64'(valid_o), 64'(1));
    check("load_regwrite", 64'(rw_o), 64'(1));

    // stall hold
    d2_i = 32'h1234; step();
    stall_in = 1; d2_i = 32'hFFFF; d1_i = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_r_data2", 64'(d2_o), 64'h1234);
      check("stall_count", 64'(cnt_o), 64'(0));
    end

    // flush
    idle_inputs();
    valid_in = 1; ctl_i[4] = 1; se_i = 32'h10;
    step();
    flush_in = 1; se_i = 32'h77;
    step();
    check("flush_valid", 64'(valid_o), 64'(0));
    check("flush_memwrite", 64'(mw_o), 64'(0));
    check("flush_sign_ext", 64'(se_o), 64'h10);
    check("flush_count", 64'(cnt_o), 64'(1));

    // load-use: lw with rt=8, followed by a reader of r8
    idle_inputs();
    valid_in = 1; ctl_i[5] = 1; ctl_i[7] = 1; ctl_i[8] = 1; rt_i = 8; rs_i = 2;
    step();
    idle_inputs();
    valid_in = 1; rs_i = 8; rt_i = 3; rd_i = 9; ctl_i[8] = 1; ctl_i[1:0] = 2'b10;
    #1 check("lu_raised", 64'(lus_o), 64'(1));
    step();
    check("lu_bubble_valid", 64'(valid_o), 64'(0));
    check("lu_bubble_count", 64'(cnt_o), 64'(2));
    #1 check("lu_cleared", 64'(lus_o), 64'(0));
    step();
    check("lu_reload_valid", 64'(valid_o), 64'(1));
    check("lu_reload_rs", 64'(rs_o), 64'(8));

    // load to $zero never stalls
    idle_inputs();
    valid_in = 1; ctl_i[5] = 1; rt_i = 0;
    step();
    ctl_i = '0; rs_i = 0; rt_i = 0;
    #1 check("lu_zero_reg", 64'(lus_o), 64'(0));
    step();

    // flush beats stall
    stall_in = 1; flush_in = 1;
    step();
    check("flush_stall_valid", 64'(valid_o), 64'(0));
    check("flush_stall_count", 64'(cnt_o), 64'(3));

    // reset in the middle of a stall, with a hazard pending
    idle_inputs();
    valid_in = 1; ctl_i[5] = 1; rt_i = 4; step();
    stall_in = 1; rs_i = 4; step();
    reset = 1; step();
    check("reset_stall_lu", 64'(lus_o), 64'(0));
    check("reset_stall_data", 64'(rt_o), 64'(0));

    // saturation
    idle_inputs();
    flush_in = 1;
    for (int i = 0; i < 10; i++) step();
    check("saturated", 64'(cnt_o), 64'(CMAX));
    reset = 1; step();
    check("sat_reset", 64'(cnt_o), 64'(0));

    // random traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      flush_in = ($urandom_range(0, 9) == 0);
      stall_in = ($urandom_range(0, 5) == 0);
      valid_in = ($urandom_range(0, 5) != 0);
      pc_i = $urandom; d1_i = $urandom; d2_i = $urandom; se_i = $urandom;
      rs_i = W'($urandom_range(0, 3));
      rt_i = W'($urandom_range(0, 3));
      rd_i = W'($urandom);
      ctl_i = 9'($urandom);
      if ($urandom_range(0, 1) == 1) ctl_i[5] = 1'b1;
      if (!valid_in) ctl_i = '0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "bench did not finish");
  end

endmodule
